debounce_pulse_tx: RTL and testbench
====================================

# debounce_pulse_tx

Transmit-side companion to the board's input debounce filters. It converts single-cycle event requests from control logic into clean active-low pulses on an output pin. Each pulse has a guaranteed minimum low time and a guaranteed minimum high gap, both timed by a local prescaler. A far-end debounce filter sampling on a slow tick therefore always registers every event exactly once. Requests that arrive while a pulse is in flight are counted and replayed in order.

## Interface
Parameters:
- DIV_COUNT, 16'd999, prescaler terminal count; one tick = DIV_COUNT+1 clk cycles
- ASSERT_TICKS, 8'd8, low-phase length in ticks (1..255)
- GAP_TICKS, 8'd8, post-pulse high-gap length in ticks (1..255)
- PEND_W, 3, width of pending-request counter (1..8)

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pulse_req_i  in  1  single-cycle event request
- ovf_clr_i  in  1  clears ovf_o
- signal_o  out  1  active-low pulse output, idle high
- busy_o  out  1  high in ASSERT or GAP
- pending_o  out  PEND_W  queued requests not yet started
- ovf_o  out  1  sticky: a request was lost

## Operation
- Reset values: signal_o=1, busy_o=0, pending_o=0, ovf_o=0, state IDLE, prescaler=0, tick counter=0.
- The design has three states: IDLE, ASSERT, GAP. All outputs are registered.
- IDLE → ASSERT when pulse_req_i=1 or pending_o≠0.
  - signal_o←0 on the same edge.
  - The prescaler and tick counter are cleared.
  - If the entry was caused by pending_o≠0, pending decrements. A concurrent req then increments it, so the net is unchanged.
- ASSERT: the 16-bit prescaler counts 0..DIV_COUNT and wraps. Each wrap increments an 8-bit tick counter. When the tick counter reaches ASSERT_TICKS:
  - state → GAP
  - signal_o←1
  - prescaler and tick counter cleared
- GAP: same counting scheme. When the tick counter reaches GAP_TICKS:
  - if pending_o≠0 or req this cycle: → ASSERT directly, with the same decrement and entry rules as from IDLE
  - otherwise: → IDLE
- A req in ASSERT or GAP (not consumed by a GAP→ASSERT transition) increments pending_o.
  - At saturation (2^PEND_W−1), the count holds and ovf_o←1.
- ovf_o clears on ovf_clr_i=1. If a new overflow occurs in the same cycle, set wins.
- Reset asserted mid-pulse: signal_o returns high on the next edge, all pending requests are discarded, and no pulse follows.

## Timing
- Latency: req sampled at edge N from IDLE → signal_o low after edge N.
- Low phase: exactly ASSERT_TICKS×(DIV_COUNT+1) clk cycles.
- High gap: exactly GAP_TICKS×(DIV_COUNT+1) cycles.
- With pending work, back-to-back pulse period is (ASSERT_TICKS+GAP_TICKS)×(DIV_COUNT+1). There is no IDLE cycle between pulses.
- busy_o equals (state≠IDLE), updated on the same edge as signal_o.
- Prescaler is held at 0 in IDLE; no free-running phase offset.

## Configuration
- DEBOUNCE_TX_QUEUE_EN defined: pending counter present, behaviour as above.
- DEBOUNCE_TX_QUEUE_EN undefined:
  - No pending counter; pending_o is tied to 0.
  - Any req in ASSERT or GAP is dropped and sets ovf_o.
  - GAP always ends in IDLE unless req is high on the final GAP cycle. That req starts the next pulse and is not dropped.

## Test plan
All cases use DIV_COUNT=3, ASSERT_TICKS=4, GAP_TICKS=2, PEND_W=3, with the macro defined unless stated. These give a 16-cycle low phase and an 8-cycle gap.
- Single req at cycle 0 → signal_o low cycles 1–16, high from 17; busy_o high cycles 1–24; IDLE at cycle 25.
- Reqs at cycles 0, 5, 6 → pending_o peaks at 2; three 16-cycle low pulses separated by 8-cycle gaps; pending_o=0 after the third pulse starts.
- PEND_W=2, five reqs during the first ASSERT → pending_o saturates at 3, ovf_o=1, exactly 4 pulses total; one ovf_clr_i pulse → ovf_o=0.
- Req at the final GAP cycle while pending_o=1 → next pulse starts immediately and pending_o stays 1.
- Reset high at the 10th low cycle with pending_o=2 → next edge: signal_o=1, busy_o=0, pending_o=0; no pulses for 100 cycles.
- Macro undefined: req during GAP → no extra pulse, ovf_o=1, pending_o=0 throughout.

Source files
------------

// File: rtl/debounce_pulse_tx.sv
// debounce_pulse_tx: turns single-cycle requests into prescaler-timed active-low pulses.
// Optional request queue is enabled by defining DEBOUNCE_TX_QUEUE_EN.
module debounce_pulse_tx #(
  parameter logic [15:0] DIV_COUNT    = 16'd999,
  parameter logic [7:0]  ASSERT_TICKS = 8'd8,
  parameter logic [7:0]  GAP_TICKS    = 8'd8,
  parameter int          PEND_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_req_i,
  input  logic              ovf_clr_i,
  output logic              signal_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              ovf_o
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ASSERT = 2'd1, S_GAP = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  tick_q, tick_d, tick_lim;
  logic        signal_q, signal_d, busy_q, busy_d, ovf_q, ovf_d;
  logic        phase_end, have_pend, start, absorb, ovf_set;

`ifdef DEBOUNCE_TX_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  logic [PEND_W-1:0] pending_q, pending_d;

  assign have_pend = (pending_q != '0);
  assign pending_o = pending_q;

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end
`else
  assign have_pend = 1'b0;
  assign pending_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      tick_q   <= '0;
      signal_q <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tick_q   <= tick_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // Phase ends on the last cycle of its final tick so the output edge lands exactly on the tick boundary.
  always_comb begin
    tick_lim  = (state_q == S_ASSERT) ? ASSERT_TICKS : GAP_TICKS;
    phase_end = (state_q != S_IDLE) && (presc_q == DIV_COUNT) && (tick_q == tick_lim - 8'd1);
    start     = ((state_q == S_IDLE) || ((state_q == S_GAP) && phase_end)) &&
                (pulse_req_i || have_pend);
    state_d   = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ASSERT;
      S_ASSERT: if (phase_end) state_d = S_GAP;
      S_GAP:    if (phase_end) state_d = start ? S_ASSERT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    absorb  = pulse_req_i && (state_q != S_IDLE) && !start;
    presc_d = '0;
    tick_d  = '0;
    if ((state_q != S_IDLE) && !phase_end) begin
      if (presc_q == DIV_COUNT) begin
        tick_d = tick_q + 8'd1;
      end else begin
        presc_d = presc_q + 16'd1;
        tick_d  = tick_q;
      end
    end
    signal_d = (state_d != S_ASSERT);
    busy_d   = (state_d != S_IDLE);
`ifdef DEBOUNCE_TX_QUEUE_EN
    pending_d = pending_q;
    ovf_set   = 1'b0;
    // A request arriving as a queued pulse launches just takes its slot: net count unchanged.
    if (start && have_pend && !pulse_req_i) begin
      pending_d = pending_q - PEND_ONE;
    end else if (absorb) begin
      if (pending_q == PEND_MAX) ovf_set = 1'b1;
      else                       pending_d = pending_q + PEND_ONE;
    end
`else
    ovf_set = absorb;
`endif
    ovf_d = ovf_set || (ovf_q && !ovf_clr_i);
  end

  assign signal_o = signal_q;
  assign busy_o   = busy_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_debounce_pulse_tx.sv
// Scoreboarded bench for debounce_pulse_tx; reference model works on pulse start times.
// Tracks DEBOUNCE_TX_QUEUE_EN so the model matches whichever build is compiled.
module tb_debounce_pulse_tx;
  localparam logic [15:0] DIV = 16'd3;
  localparam logic [7:0]  AT  = 8'd4;
  localparam logic [7:0]  GT  = 8'd2;
  localparam int          PW  = 3;
  localparam int LOW = int'(AT) * (int'(DIV) + 1);
  localparam int PER = LOW + int'(GT) * (int'(DIV) + 1);
`ifdef DEBOUNCE_TX_QUEUE_EN
  localparam int CAP = (1 << PW) - 1;
`else
  localparam int CAP = 0;
`endif

  logic clk = 1'b0, reset = 1'b0, pulse_req = 1'b0, ovf_clr = 1'b0;
  logic signal_o, busy_o, ovf_o;
  logic [PW-1:0] pending_o;

  debounce_pulse_tx #(
    .DIV_COUNT(DIV), .ASSERT_TICKS(AT), .GAP_TICKS(GT), .PEND_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .pulse_req_i(pulse_req), .ovf_clr_i(ovf_clr),
    .signal_o(signal_o), .busy_o(busy_o), .pending_o(pending_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int starts[$];
  int exp_q[$];
  int last_start = -100000;
  bit m_ovf = 1'b0, armed = 1'b0;
  int exp_sig = 1, exp_busy = 0, exp_pend = 0;
  logic prev_sig = 1'b1;

  // A request starts at max(now, previous start + period); it is lost when it would have to wait
  // and the wait list is already full.
  task automatic model_edge(input logic r, input logic c, input logic rs);
    int k = cyc;
    int s;
    int cnt = 0;
    bit drop = 1'b0;
    if (rs) begin
      starts.delete();
      exp_q.delete();
      last_start = -100000;
      m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      foreach (starts[i]) if (starts[i] > k) cnt++;
      if (r) begin
        s = (last_start + PER > k) ? last_start + PER : k;
        if (s > k && cnt >= CAP) drop = 1'b1;
        else begin
          starts.push_back(s);
          exp_q.push_back(s);
          last_start = s;
        end
      end
      m_ovf = drop || (m_ovf && !c);
    end
    exp_sig = 1; exp_busy = 0; exp_pend = 0;
    foreach (starts[i]) begin
      if (starts[i] <= k && k < starts[i] + LOW) exp_sig = 0;
      if (starts[i] <= k && k < starts[i] + PER) exp_busy = 1;
      if (starts[i] > k) exp_pend++;
    end
    while (starts.size() > 0 && starts[0] + PER <= k) void'(starts.pop_front());
  endtask

  task automatic step(input logic r, input logic c, input logic rs);
    pulse_req = r; ovf_clr = c; reset = rs;
    @(posedge clk);
    cyc++;
    model_edge(r, c, rs);
    #1;
  endtask

  task automatic play(input logic [255:0] mask, input int len, input int rst_at);
    for (int i = 0; i < len; i++) step(mask[i] && (i != rst_at), 1'b0, i == rst_at);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle output checks plus a pulse-start scoreboard popped on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("signal_o", int'(signal_o), exp_sig);
      chk("busy_o", int'(busy_o), exp_busy);
      chk("pending_o", int'(pending_o), exp_pend);
      chk("ovf_o", int'(ovf_o), int'(m_ovf));
      if (prev_sig && !signal_o) begin
        if (exp_q.size() == 0) chk("pulse_unexpected", cyc, -1);
        else                   chk("pulse_start", cyc, exp_q.pop_front());
      end
      prev_sig = signal_o;
    end
  end

  logic rs_r;

  initial begin
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    play(256'h1, 30, -1);
    play(256'h61, 90, -1);
    play(256'h1FF, 202, -1);
    step(1'b0, 1'b1, 1'b0);
    play('0, 5, -1);
    play(256'hD, 100, -1);
    play(256'h7, 111, 10);
    play(256'h1 | (256'h1 << 20), 40, -1);
    for (int i = 0; i < 3000; i++) begin
      rs_r = ($urandom_range(0, 799) == 0);
      step(!rs_r && ($urandom_range(0, 11) == 0), $urandom_range(0, 49) == 0, rs_r);
    end
    play('0, 250, -1);
    chk("pulses_outstanding", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
